bsg_cgol_ctrl: RTL and testbench

Sequencing controller for the Game of Life board of `bsg_cgol_cell` instances. It accepts a seed board and a generation count on a ready/valid input, and loads the seed into every cell in one cycle. It then steps the whole grid for the requested number of generations and presents the final board on a valid/yumi output. It sits between the host-side board interface and the cell array, and drives the shared `en_i`, `update_i` and `update_val_i` inputs of all cells.

---
 rtl/bsg_cgol_ctrl.sv | 74 +++++++
 tb/tb_bsg_cgol_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bsg_cgol_ctrl.sv
// bsg_cgol_ctrl: loads a seed board into the cell array, steps it N generations,
// then holds the final board on a valid/yumi output until consumed.
module bsg_cgol_ctrl #(
    parameter  int board_width_p     = 8,
    parameter  int max_game_length_p = 10,
    localparam int cells_lp          = board_width_p * board_width_p,
    localparam int frames_width_lp   = $clog2(max_game_length_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [cells_lp-1:0]        data_i,
    input  logic [frames_width_lp-1:0] frames_i,
    input  logic                       v_i,
    output logic                       ready_o,
    output logic                       en_o,
    output logic                       update_o,
    output logic [cells_lp-1:0]        update_val_o,
    input  logic [cells_lp-1:0]        cells_i,
    output logic [cells_lp-1:0]        data_o,
    output logic                       v_o,
    input  logic                       yumi_i
);
    typedef enum logic [1:0] {eIDLE, eRUN, eDONE} state_e;

    state_e                     r_state, w_state_n;
    logic [frames_width_lp-1:0] r_cnt, w_cnt_n;

    assign update_val_o = data_i;
    assign data_o       = cells_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= eIDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    // Handshake outputs are gated by reset so nothing leaks out in the reset cycle.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        ready_o   = 1'b0;
        en_o      = 1'b0;
        update_o  = 1'b0;
        v_o       = 1'b0;
        case (r_state)
            eIDLE: begin
                ready_o  = ~reset_i;
                update_o = v_i & ~reset_i;
                if (v_i) begin
                    w_cnt_n   = frames_i;
                    w_state_n = (frames_i == '0) ? eDONE : eRUN;
                end
            end
            eRUN: begin
                en_o      = ~reset_i;
                w_cnt_n   = (r_cnt != '0) ? r_cnt - frames_width_lp'(1) : '0;
                w_state_n = (r_cnt == frames_width_lp'(1)) ? eDONE : eRUN;
            end
            eDONE: begin
                v_o       = ~reset_i;
                w_state_n = yumi_i ? eIDLE : eDONE;
            end
            default: w_state_n = eIDLE;
        endcase
    end

    always_ff @(posedge clk_i)
        if (!reset_i && r_state == eIDLE && v_i)
            assert (frames_i <= frames_width_lp'(max_game_length_p));
endmodule

// File: tb/tb_bsg_cgol_ctrl.sv
// tb_bsg_cgol_ctrl: drives games through the controller over a 4x4 behavioural cell
// array and checks every output each cycle against a game-timeline model.
module tb_bsg_cgol_ctrl;
    logic        clk = 1'b0, reset_i = 1'b1, v_i = 1'b0, yumi_i = 1'b0;
    logic [15:0] data_i = '0, cells = '0;
    logic [3:0]  frames_i = '0;
    logic        ready_o, en_o, update_o, v_o;
    logic [15:0] update_val_o, data_o;
    int          checks = 0, failures = 0;
    logic        m_game = 1'b0;
    int          m_s = 0, m_n = 0;
    logic [15:0] m_exp = '0;
    logic [15:0] b_seed [4] = '{16'h0070, 16'h0660, 16'h0070, 16'h0070};
    int          b_n    [4] = '{1, 0, 2, 3};
    logic [15:0] b_exp  [4] = '{16'h0222, 16'h0660, 16'h0070, 16'h0222};

    bsg_cgol_ctrl #(.board_width_p(4), .max_game_length_p(10)) dut (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .frames_i(frames_i), .v_i(v_i),
        .ready_o(ready_o), .en_o(en_o), .update_o(update_o), .update_val_o(update_val_o),
        .cells_i(cells), .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i)
    );

    always #5 clk = ~clk;

    // Conway rules on a 4x4 board; cells beyond the edge count as dead.
    function automatic logic [15:0] life_step(input logic [15:0] b);
        logic [15:0] nb;
        int k;
        nb = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                k = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 4 && c + dc >= 0 && c + dc < 4)
                            k += int'(b[(r + dr) * 4 + c + dc]);
                nb[r * 4 + c] = (k == 3) || (b[r * 4 + c] && k == 2);
            end
        return nb;
    endfunction

    function automatic logic [15:0] life_n(input logic [15:0] b, input int n);
        logic [15:0] x;
        x = b;
        for (int i = 0; i < n; i++) x = life_step(x);
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk)
        if (update_o) cells <= update_val_o;
        else if (en_o) cells <= life_step(cells);

    // Timeline model: m_s counts cycles since accept; run for 1..N, result from N+1.
    always @(posedge clk) begin
        if (reset_i) m_game <= 1'b0;
        else if (!m_game) begin
            if (v_i) begin
                m_game <= 1'b1;
                m_s    <= 1;
                m_n    <= int'(frames_i);
                m_exp  <= life_n(data_i, int'(frames_i));
            end
        end else if (m_s > m_n) begin
            if (yumi_i) m_game <= 1'b0;
        end else m_s <= m_s + 1;
    end

    always @(negedge clk) begin
        chk("update_val", update_val_o, data_i);
        if (reset_i) begin
            chk("rst_ready_o", ready_o, 0);
            chk("rst_update_o", update_o, 0);
            chk("rst_en_o", en_o, 0);
            chk("rst_v_o", v_o, 0);
        end else if (!m_game) begin
            chk("idle_ready_o", ready_o, 1);
            chk("idle_en_o", en_o, 0);
            chk("idle_v_o", v_o, 0);
            chk("idle_update_o", update_o, v_i);
        end else begin
            chk("game_ready_o", ready_o, 0);
            chk("game_update_o", update_o, 0);
            chk("game_en_o", en_o, m_s <= m_n);
            chk("game_v_o", v_o, m_s > m_n);
            if (m_s > m_n) chk("game_data_o", data_o, m_exp);
        end
    end

    task automatic play(input logic [15:0] seed, input int n, input int hold, input logic [15:0] exp);
        int s, en_seen;
        data_i = seed; frames_i = 4'(n); v_i = 1'b1;
        @(posedge clk); #1;
        v_i = 1'b0; data_i = 16'hA5C3;
        s = 1; en_seen = 0;
        forever begin
            @(negedge clk);
            if (v_o || s > n + 4) break;
            en_seen += int'(en_o);
            s++;
            @(posedge clk); #1;
        end
        chk("v_o_seen", v_o, 1);
        chk("latency", s, n + 1);
        chk("en_cycles", en_seen, n);
        chk("cnt_zero", dut.r_cnt, 0);
        chk("board", data_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            v_i = 1'b1; frames_i = 4'd1;
            @(negedge clk);
            chk("hold_v_o", v_o, 1);
            chk("hold_data_o", data_o, exp);
            chk("hold_no_accept", ready_o, 0);
        end
        #1;
        v_i = 1'b0; yumi_i = 1'b1;
        @(posedge clk); #1;
        yumi_i = 1'b0;
        @(negedge clk);
        chk("ready_after_yumi", ready_o, 1);
        #1;
    endtask

    initial begin
        int s;
        chk("model_blinker1", life_n(16'h0070, 1), 16'h0222);
        chk("model_blinker2", life_n(16'h0070, 2), 16'h0070);
        chk("model_block", life_n(16'h0660, 5), 16'h0660);
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        chk("reset_ready", ready_o, 1);
        chk("reset_cnt", dut.r_cnt, 0);
        #1;
        play(16'h0070, 1, 0, 16'h0222);
        play(16'h0070, 2, 0, 16'h0070);
        play(16'h0660, 0, 0, 16'h0660);
        play(16'h0070, 10, 5, 16'h0070);
        data_i = 16'h0070; frames_i = 4'd5; v_i = 1'b1;
        @(posedge clk); #1 v_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b1;
        @(negedge clk);
        chk("mid_reset_en_o", en_o, 0);
        @(posedge clk); #1 reset_i = 1'b0;
        @(negedge clk);
        chk("mid_reset_ready", ready_o, 1);
        chk("mid_reset_cnt", dut.r_cnt, 0);
        #1;
        play(16'h0070, 3, 0, 16'h0222);
        yumi_i = 1'b1; v_i = 1'b1;
        for (int g = 0; g < 4; g++) begin
            data_i = b_seed[g]; frames_i = 4'(b_n[g]);
            @(posedge clk); #1;
            s = 1;
            forever begin
                @(negedge clk);
                if (v_o) chk("b2b_board", data_o, b_exp[g]);
                if (ready_o || s > b_n[g] + 5) break;
                s++;
                @(posedge clk); #1;
            end
            chk("b2b_period", s, b_n[g] + 2);
            #1;
        end
        v_i = 1'b0; yumi_i = 1'b0;
        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
